// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: 32-step radix-2 Booth MULT and restoring DIV with HI/LO result registers.
// Optional MULDIV_ABORT_EN macro adds an `abort` input that cancels an in-flight operation.
module muldiv_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
`ifdef MULDIV_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        hi_write,
    output logic        lo_write,
    output logic        div_zero
);

    localparam int unsigned XLEN      = 32;
    localparam int unsigned CNTW      = 6;
    localparam int unsigned LAST_STEP = XLEN - 1;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MULT_RUN = 2'd1,
        DIV_RUN  = 2'd2,
        FINISH   = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]   opa_q, opa_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [XLEN:0]     acc_q, acc_d;
    logic [XLEN-1:0]   wlo_q, wlo_d;
    logic              q1_q, q1_d;
    logic              zero_q, zero_d;
    logic              is_div_q, is_div_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              hi_write_q, hi_write_d;
    logic              lo_write_q, lo_write_d;
    logic              div_zero_q, div_zero_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic              abort_c;
    logic [XLEN-1:0]   abs_a_c;
    logic [XLEN-1:0]   abs_b_c;
    logic [XLEN:0]     m_ext_c;
    logic [XLEN:0]     booth_sum_c;
    logic [XLEN:0]     div_shift_c;
    logic [XLEN:0]     div_diff_c;
    logic              div_ge_c;
    logic [XLEN-1:0]   quo_c;
    logic [XLEN-1:0]   rem_c;

`ifdef MULDIV_ABORT_EN
    assign abort_c = abort;
`else
    assign abort_c = 1'b0;
`endif

    // Magnitudes for the divider; 0x80000000 maps onto itself, which is the correct unsigned magnitude.
    assign abs_a_c = op_a[XLEN-1] ? XLEN'(-op_a) : op_a;
    assign abs_b_c = opb_q[XLEN-1] ? XLEN'(-opb_q) : opb_q;

    // Booth step: 33-bit accumulator so that subtracting -2^31 cannot overflow.
    assign m_ext_c = {opa_q[XLEN-1], opa_q};
    always_comb begin
        booth_sum_c = acc_q;
        case ({wlo_q[0], q1_q})
            2'b01:   booth_sum_c = acc_q + m_ext_c;
            2'b10:   booth_sum_c = acc_q - m_ext_c;
            default: booth_sum_c = acc_q;
        endcase
    end

    // Restoring step: shift remainder left by one dividend bit and try to subtract the divisor.
    assign div_shift_c = {acc_q[XLEN-1:0], wlo_q[XLEN-1]};
    assign div_ge_c    = div_shift_c >= {1'b0, abs_b_c};
    assign div_diff_c  = div_shift_c - {1'b0, abs_b_c};

    assign quo_c = (opa_q[XLEN-1] ^ opb_q[XLEN-1]) ? XLEN'(-wlo_q) : wlo_q;
    assign rem_c = opa_q[XLEN-1] ? XLEN'(-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];

    // Next-state and datapath control.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        acc_d      = acc_q;
        wlo_d      = wlo_q;
        q1_d       = q1_q;
        zero_d     = zero_q;
        is_div_d   = is_div_q;
        busy_d     = busy_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        hi_write_d = 1'b0;
        lo_write_d = 1'b0;
        div_zero_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_mult) begin
                    opa_d    = op_a;
                    opb_d    = op_b;
                    cnt_d    = '0;
                    acc_d    = '0;
                    wlo_d    = op_b;
                    q1_d     = 1'b0;
                    zero_d   = 1'b0;
                    is_div_d = 1'b0;
                    busy_d   = 1'b1;
                    state_d  = MULT_RUN;
                end else if (start_div) begin
                    opa_d    = op_a;
                    opb_d    = op_b;
                    cnt_d    = '0;
                    acc_d    = '0;
                    wlo_d    = abs_a_c;
                    q1_d     = 1'b0;
                    zero_d   = (op_b == '0);
                    is_div_d = 1'b1;
                    busy_d   = 1'b1;
                    state_d  = (op_b == '0) ? FINISH : DIV_RUN;
                end
            end
            MULT_RUN: begin
                if (abort_c) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d = {booth_sum_c[XLEN], booth_sum_c[XLEN:1]};
                    wlo_d = {booth_sum_c[0], wlo_q[XLEN-1:1]};
                    q1_d  = wlo_q[0];
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(LAST_STEP)) begin
                        state_d = FINISH;
                    end
                end
            end
            DIV_RUN: begin
                if (abort_c) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    acc_d = div_ge_c ? div_diff_c : div_shift_c;
                    wlo_d = {wlo_q[XLEN-2:0], div_ge_c};
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(LAST_STEP)) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (zero_q) begin
                    div_zero_d = 1'b1;
                end else begin
                    hi_write_d = 1'b1;
                    lo_write_d = 1'b1;
                    hi_d       = is_div_q ? rem_c : acc_q[XLEN-1:0];
                    lo_d       = is_div_q ? quo_c : wlo_q;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            acc_q      <= '0;
            wlo_q      <= '0;
            q1_q       <= 1'b0;
            zero_q     <= 1'b0;
            is_div_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hi_write_q <= 1'b0;
            lo_write_q <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            acc_q      <= acc_d;
            wlo_q      <= wlo_d;
            q1_q       <= q1_d;
            zero_q     <= zero_d;
            is_div_q   <= is_div_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            hi_write_q <= hi_write_d;
            lo_write_q <= lo_write_d;
            div_zero_q <= div_zero_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hi_out   = hi_q;
    assign lo_out   = lo_q;
    assign hi_write = hi_write_q;
    assign lo_write = lo_write_q;
    assign div_zero = div_zero_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl: latency, MULT/DIV results, divide-by-zero, contention, reset.
module tb_muldiv_ctrl;

    logic        clock;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        abort;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        hi_write;
    logic        lo_write;
    logic        div_zero;

    int errors = 0;
    int checks = 0;
    int lat;
    int bcyc;
    int ndone;

    muldiv_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
`ifdef MULDIV_ABORT_EN
        .abort      (abort),
`endif
        .busy       (busy),
        .done       (done),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .hi_write   (hi_write),
        .lo_write   (lo_write),
        .div_zero   (div_zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Launch one op at the next edge (E0); return edges from E0 to done (-1 on timeout) and busy cycles.
    // A stray start_div is held high across edge E0+inj when inj > 0.
    task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                         input int inj, output int l, output int bc);
        start_mult = m;
        start_div  = d;
        op_a       = a;
        op_b       = b;
        @(posedge clock);
        @(negedge clock);
        start_mult = 1'b0;
        start_div  = 1'b0;
        l  = -1;
        bc = 0;
        for (int n = 1; n <= 40 && l < 0; n++) begin
            if (busy) bc++;
            if (inj > 0 && n == inj) start_div = 1'b1;
            if (inj > 0 && n == inj + 1) start_div = 1'b0;
            @(posedge clock);
            @(negedge clock);
            if (done) l = n;
        end
        start_div = 1'b0;
    endtask

    task automatic count_done(input int ncyc, output int cnt);
        cnt = 0;
        for (int n = 0; n < ncyc; n++) begin
            @(negedge clock);
            if (done) cnt++;
        end
    endtask

    initial begin
        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        abort      = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_wr", 64'({hi_write, lo_write, div_zero}), 64'd0);
        reset = 1'b0;
        @(negedge clock);

        // 7 * -3
        do_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 0, lat, bcyc);
        chk("mul1_lat", 64'(lat), 64'd33);
        chk("mul1_busy_cycles", 64'(bcyc), 64'd33);
        chk("mul1_busy_at_done", 64'(busy), 64'd0);
        chk("mul1_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("mul1_lo", 64'(lo_out), 64'hFFFF_FFEB);
        chk("mul1_wr", 64'({hi_write, lo_write, div_zero}), 64'b110);
        @(negedge clock);
        chk("mul1_done_pulse", 64'({done, hi_write, lo_write}), 64'd0);

        do_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, lat, bcyc);
        chk("mul_maxpos", 64'({hi_out, lo_out}), 64'h3FFF_FFFF_0000_0001);
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 0, lat, bcyc);
        chk("mul_minneg", 64'({hi_out, lo_out}), 64'h4000_0000_0000_0000);

        // -7 / 2
        do_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, lat, bcyc);
        chk("div1_lat", 64'(lat), 64'd33);
        chk("div1_lo", 64'(lo_out), 64'hFFFF_FFFD);
        chk("div1_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("div1_wr", 64'({hi_write, lo_write, div_zero}), 64'b110);
        do_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bcyc);
        chk("div_ovf", 64'({hi_out, lo_out}), 64'h0000_0000_8000_0000);
        do_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 0, lat, bcyc);
        chk("div_negdivisor", 64'({hi_out, lo_out}), 64'h0000_0002_FFFF_FFF2);

        // Preload HI=5, LO=9 via 59/6, then divide by zero.
        do_op(1'b0, 1'b1, 32'd59, 32'd6, 0, lat, bcyc);
        chk("div_preload", 64'({hi_out, lo_out}), 64'h0000_0005_0000_0009);
        do_op(1'b0, 1'b1, 32'd1234, 32'd0, 0, lat, bcyc);
        chk("dz_lat", 64'(lat), 64'd1);
        chk("dz_busy_cycles", 64'(bcyc), 64'd1);
        chk("dz_flags", 64'({done, div_zero, hi_write, lo_write}), 64'b1100);
        chk("dz_hilo", 64'({hi_out, lo_out}), 64'h0000_0005_0000_0009);
        @(negedge clock);
        chk("dz_pulse", 64'({done, div_zero}), 64'd0);

        // Both starts together, plus a late start_div at E0+5.
        do_op(1'b1, 1'b1, 32'd3, 32'd4, 5, lat, bcyc);
        chk("cont_lat", 64'(lat), 64'd33);
        chk("cont_res", 64'({hi_out, lo_out}), 64'h0000_0000_0000_000C);
        chk("cont_dz", 64'(div_zero), 64'd0);
        count_done(40, ndone);
        chk("cont_single_done", 64'(ndone), 64'd0);

        // Reset at E0+10 of a multiply.
        start_mult = 1'b1;
        op_a       = 32'd100;
        op_b       = 32'd100;
        @(posedge clock);
        @(negedge clock);
        start_mult = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("mrst_outs", 64'({busy, done, hi_write, lo_write, div_zero}), 64'd0);
        chk("mrst_hilo", 64'({hi_out, lo_out}), 64'd0);
        reset = 1'b0;
        count_done(40, ndone);
        chk("mrst_no_done", 64'(ndone), 64'd0);
        do_op(1'b1, 1'b0, 32'd2, 32'd2, 0, lat, bcyc);
        chk("mrst_after_lat", 64'(lat), 64'd33);
        chk("mrst_after_res", 64'({hi_out, lo_out}), 64'd4);

`ifdef MULDIV_ABORT_EN
        // Abort at E0+12 of a divide.
        start_div = 1'b1;
        op_a      = 32'd100;
        op_b      = 32'd7;
        @(posedge clock);
        @(negedge clock);
        start_div = 1'b0;
        repeat (11) @(negedge clock);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        count_done(40, ndone);
        chk("abort_no_done", 64'(ndone), 64'd0);
        chk("abort_hilo", 64'({hi_out, lo_out}), 64'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port `clock`, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-004 Port `start_mult`, input, 1 bit: control-unit request for a signed multiply (MULT).
REQ-005 Port `start_div`, input, 1 bit: control-unit request for a signed divide (DIV).
REQ-006 Port `op_a`, input, 32 bits: operand A (register A value); dividend or multiplicand.
REQ-007 Port `op_b`, input, 32 bits: operand B (register B value); divisor or multiplier.
REQ-008 Port `busy`, output, 1 bit: high while an operation is in flight; the control unit stalls on it.
REQ-009 Port `done`, output, 1 bit: one-cycle completion pulse.
REQ-010 Port `hi_out`, output, 32 bits: HI result, feeding the HI register input.
REQ-011 Port `lo_out`, output, 32 bits: LO result, feeding the LO register input.
REQ-012 Port `hi_write`, output, 1 bit: HI load enable; equals `done` except on divide-by-zero.
REQ-013 Port `lo_write`, output, 1 bit: LO load enable; same rule as `hi_write`.
REQ-014 Port `div_zero`, output, 1 bit: one-cycle pulse, coincident with `done`, when the divisor was 0.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, MULT_RUN, DIV_RUN, FINISH.
REQ-016 In IDLE, when `start_mult`=1 is sampled at edge E0: latch `op_a`/`op_b`, clear the 6-bit iteration counter, go to MULT_RUN.
REQ-017 In IDLE, when `start_div`=1 and `start_mult`=0 are sampled: latch operands; if `op_b`==0 go to FINISH with a zero flag set, otherwise go to DIV_RUN.
REQ-018 When `start_mult` and `start_div` are both high, the multiply SHALL take priority and the divide request SHALL be discarded.
REQ-019 Start requests sampled in any state other than IDLE SHALL be ignored, with no queuing.
REQ-020 MULT_RUN SHALL perform one radix-2 Booth step per cycle for 32 cycles, then go to FINISH.
REQ-021 DIV_RUN SHALL perform one restoring-division step per cycle on the operand magnitudes for 32 cycles, apply sign correction, then go to FINISH.
REQ-022 `busy` SHALL be high from the cycle after E0 through the FINISH cycle inclusive.
REQ-023 FINISH SHALL last one cycle, raise `done`, then return to IDLE. `done` SHALL rise at edge E0+33 for MULT and DIV, and at edge E0+1 for divide-by-zero.
REQ-024 MULT result: {`hi_out`,`lo_out`} SHALL equal the 64-bit two's-complement product of signed `op_a` × `op_b`.
REQ-025 DIV result: `lo_out` SHALL be the quotient truncated toward zero; `hi_out` SHALL be the remainder, carrying the dividend's sign.
REQ-026 DIV of 0x80000000 by 0xFFFFFFFF SHALL give `lo_out`=0x80000000 and `hi_out`=0, with no exception.
REQ-027 On divide-by-zero: `done`=1, `div_zero`=1, `hi_write`=`lo_write`=0, and `hi_out`/`lo_out` keep their prior values.
REQ-028 `hi_out`/`lo_out` SHALL hold the last result until the next FINISH and SHALL be stable during FINISH.

Reset
REQ-029 While `reset`=1 at a rising edge, the state SHALL become IDLE, the counter and operand registers SHALL clear, and `busy`, `done`, `hi_write`, `lo_write`, `div_zero` SHALL be 0 and `hi_out`, `lo_out` SHALL be 0x00000000.
REQ-030 Reset during MULT_RUN, DIV_RUN or FINISH SHALL abandon the operation, with no `done` pulse afterwards.
REQ-031 Reset SHALL take priority over a simultaneous `start_mult` or `start_div`.

Configuration
REQ-032 Macro `MULDIV_ABORT_EN`, when defined, SHALL add input port `abort` (1 bit).
REQ-033 With `MULDIV_ABORT_EN` defined, `abort`=1 in MULT_RUN or DIV_RUN SHALL return the FSM to IDLE at the next edge with no `done`, no writes, and `hi_out`/`lo_out` unchanged. `abort` SHALL be ignored in IDLE and FINISH.
REQ-034 Without `MULDIV_ABORT_EN`, the `abort` port SHALL NOT exist, and every accepted operation SHALL run to FINISH unless reset.

Verification
REQ-035 MULT: `op_a`=7, `op_b`=0xFFFFFFFD (-3) -> `done` at E0+33, `hi_out`=0xFFFFFFFF, `lo_out`=0xFFFFFFEB, `hi_write`=`lo_write`=1.
REQ-036 DIV: `op_a`=0xFFFFFFF9 (-7), `op_b`=2 -> `done` at E0+33, `lo_out`=0xFFFFFFFD, `hi_out`=0xFFFFFFFF; then 0x80000000/0xFFFFFFFF -> `lo_out`=0x80000000, `hi_out`=0.
REQ-037 DIV by zero: prior HI=5, LO=9; `op_b`=0 -> `done`=`div_zero`=1 at E0+1, no writes, HI/LO stay 5/9, `busy` high one cycle.
REQ-038 Contention: `start_mult` and `start_div` high together with 3×4 -> multiply result `lo_out`=12; a `start_div` at E0+5 -> ignored, a single `done` only.
REQ-039 Reset at E0+10 of a MULT -> all outputs 0 at the next edge, no `done` within 40 cycles; a new MULT 2×2 afterwards -> `lo_out`=4.
REQ-040 With `MULDIV_ABORT_EN`: `abort` at E0+12 of a DIV -> IDLE next edge, no `done`, HI/LO unchanged.
